// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Holds the PC and issues single-outstanding reads to instruction memory.
// A response that arrives while decode stalls is parked in a one-entry buffer.
// A taken branch from execute redirects the PC and discards in-flight fetches.
// The result is presented to decode as a registered IF/ID bundle.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   pc_src              taken-branch redirect from execute
//   branch_target       redirect PC (bits [1:0] ignored)
//   stall               decode cannot accept; IF/ID holds
//   imem_req/imem_addr  read request and word-aligned address
//   imem_ready          request accepted this cycle when imem_req is high
//   imem_rvalid/rdata   read response, one per accepted request
//   if_valid/if_pc/if_pc_plus4/if_instr   IF/ID bundle to decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_n;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_instr_n;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] req_pc_plus4;

    assign redirect_pc  = branch_target & ALIGN_MASK;
    assign req_pc_plus4 = req_pc + XLEN'(4);

    // Request is a pure decode of the state, suppressed while reset is held.
    assign imem_req  = (state == S_FETCH) && !reset;
    assign imem_addr = pc & ALIGN_MASK;

    // Next-state, PC and buffer update; a redirect overrides the PC last.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_pc_n    = req_pc;
        buf_instr_n = buf_instr;
        load        = 1'b0;
        load_instr  = buf_instr;

        unique case (state)
            S_FETCH: begin
                if (imem_ready) begin
                    req_pc_n = pc;
                    // Old-PC request already accepted: its response must be dropped.
                    state_n  = pc_src ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (pc_src) begin
                        state_n = S_FETCH;
                    end else if (!stall) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        pc_n       = req_pc_plus4;
                        state_n    = S_FETCH;
                    end else begin
                        buf_instr_n = imem_rdata;
                        state_n     = S_HOLD;
                    end
                end else if (pc_src) begin
                    state_n = S_DROP;
                end
            end
            S_HOLD: begin
                if (pc_src) begin
                    state_n = S_FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = buf_instr;
                    pc_n       = req_pc_plus4;
                    state_n    = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_FETCH;
        endcase

        if (pc_src) begin
            pc_n = redirect_pc;
        end
    end

    // Control state, PC and response buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            buf_instr <= NOP_INSTR;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_pc    <= req_pc_n;
            buf_instr <= buf_instr_n;
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
            if_instr    <= NOP_INSTR;
        end else if (pc_src) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                if_valid    <= 1'b1;
                if_pc       <= req_pc;
                if_pc_plus4 <= req_pc_plus4;
                if_instr    <= load_instr;
            end else begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model with configurable response delay,
// scoreboard of expected IF/ID bundles, and one task per scenario.
module tb_instruction_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    int          checks;
    int          errors;
    int          resp_delay;
    logic [31:0] exp_q[$];

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .if_instr     (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one response per accepted request, resp_delay extra cycles later.
    initial begin
        bit          s_acc;
        logic [31:0] s_addr;
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 0;
        cnt = 0;
        paddr = '0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            s_acc  = imem_req && imem_ready;
            s_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (reset) begin
                pend = 0;
            end else begin
                if (s_acc) begin
                    checks++;
                    if (pend) begin
                        errors++;
                        $display("FAIL outstanding: second request %h accepted while %h pending", s_addr, paddr);
                    end
                    pend  = 1;
                    cnt   = resp_delay;
                    paddr = s_addr;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = paddr ^ DATA_KEY;
                        pend        = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Scoreboard: every freshly loaded bundle must match the next expected PC.
    initial begin
        bit          stall_e;
        logic [31:0] e;
        logic [31:0] e4;
        stall_e = 1'b0;
        forever begin
            @(posedge clk);
            stall_e = stall;
            @(negedge clk);
            checks++;
            if (imem_addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL align: imem_addr %h low bits not zero", imem_addr);
            end
            if (!reset && if_valid && !stall_e) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bundle: unexpected if_pc %h instr %h, none expected", if_pc, if_instr);
                end else begin
                    e  = exp_q.pop_front();
                    e4 = e + 32'd4;
                    if (if_pc !== e || if_pc_plus4 !== e4 || if_instr !== (e ^ DATA_KEY)) begin
                        errors++;
                        $display("FAIL bundle: got pc %h pc4 %h instr %h, expected pc %h pc4 %h instr %h",
                                 if_pc, if_pc_plus4, if_instr, e, e4, e ^ DATA_KEY);
                    end
                end
            end
        end
    end

    task automatic step_until_addr(input logic [31:0] a, output bit found);
        found = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (imem_req && imem_addr == a) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic step_until_valid(output bit found);
        found = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (if_valid) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_req: imem_req %b expected 0", imem_req);
            end
        end
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        checks++;
        if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
        checks++;
        if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 0", if_pc_plus4); end
        checks++;
        if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        bit found;
        int vcnt;
        vcnt  = 0;
        found = 0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        resp_delay = 0;
        imem_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (if_valid) vcnt++;
            if (imem_req && imem_addr == 32'h10) begin
                found = 1;
                break;
            end
        end
        imem_ready = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL seq_reach: fetch of 00000010 not seen"); end
        checks++;
        if (vcnt != 4) begin errors++; $display("FAIL seq_valid_cycles: got %0d expected 4", vcnt); end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain: %0d left expected 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall_hold();
        bit found;
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        resp_delay = 0;
        imem_ready = 1'b1;
        step_until_valid(found);
        checks++;
        if (!found) begin errors++; $display("FAIL hold_first: bundle 00000010 not seen"); end
        stall = 1'b1;
        resp_delay = 1;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== (32'h10 ^ DATA_KEY)) begin
                errors++;
                $display("FAIL hold_stall: req %b valid %b pc %h instr %h expected 0 1 00000010 %h",
                         imem_req, if_valid, if_pc, if_instr, 32'h10 ^ DATA_KEY);
            end
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin
            errors++;
            $display("FAIL hold_next: req %b addr %h expected 1 00000018", imem_req, imem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL hold_drain: %0d left expected 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_redirect_wait();
        bit found;
        resp_delay = 2;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_ready    = 1'b0;
        pc_src        = 1'b1;
        branch_target = 32'h0000_0103;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_redir: valid %b req %b expected 0 0", if_valid, imem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_drop: req %b expected 0", imem_req); end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL wait_target: req %b addr %h expected 1 00000100", imem_req, imem_addr);
        end
        exp_q.push_back(32'h100);
        resp_delay = 0;
        imem_ready = 1'b1;
        step_until_addr(32'h104, found);
        imem_ready = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL wait_reach: fetch of 00000104 not seen"); end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wait_drain: %0d left expected 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_redirect_drop();
        bit found;
        resp_delay    = 1;
        imem_ready    = 1'b1;
        pc_src        = 1'b1;
        branch_target = 32'h0000_0180;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        pc_src     = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_enter: req %b expected 0", imem_req); end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_stay: req %b expected 0", imem_req); end
        pc_src        = 1'b1;
        branch_target = 32'h0000_0200;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL drop_target: req %b addr %h expected 1 00000200", imem_req, imem_addr);
        end
        exp_q.push_back(32'h200);
        resp_delay = 0;
        imem_ready = 1'b1;
        step_until_addr(32'h204, found);
        imem_ready = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL drop_reach: fetch of 00000204 not seen"); end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL drop_drain: %0d left expected 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush_stall();
        bit found;
        exp_q.push_back(32'h204);
        resp_delay = 0;
        imem_ready = 1'b1;
        step_until_valid(found);
        checks++;
        if (!found) begin errors++; $display("FAIL flush_first: bundle 00000204 not seen"); end
        stall = 1'b1;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h204) begin
            errors++;
            $display("FAIL flush_hold: req %b valid %b pc %h expected 0 1 00000204", imem_req, if_valid, if_pc);
        end
        pc_src        = 1'b1;
        branch_target = 32'h0000_0300;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h204) begin
            errors++;
            $display("FAIL flush_beats_stall: valid %b instr %h pc %h expected 0 %h 00000204",
                     if_valid, if_instr, if_pc, NOP);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL flush_target: req %b addr %h expected 1 00000300", imem_req, imem_addr);
        end
        stall = 1'b0;
        exp_q.push_back(32'h300);
        imem_ready = 1'b1;
        step_until_addr(32'h304, found);
        imem_ready = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL flush_reach: fetch of 00000304 not seen"); end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain: %0d left expected 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap_and_async_reset();
        bit found;
        resp_delay = 0;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_ready    = 1'b0;
        pc_src        = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        pc_src = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_redir: valid %b req %b addr %h expected 0 1 fffffffc", if_valid, imem_req, imem_addr);
        end
        exp_q.push_back(32'hFFFF_FFFC);
        imem_ready = 1'b1;
        step_until_addr(32'h0, found);
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_reach: fetch of 00000000 not seen"); end
        checks++;
        if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: pc %h pc4 %h expected fffffffc 00000000", if_pc, if_pc_plus4);
        end
        stall      = 1'b1;
        resp_delay = 2;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        checks++;
        if (if_valid !== 1'b1) begin errors++; $display("FAIL wrap_held: valid %b expected 1", if_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 || if_instr !== NOP || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid %b pc %h pc4 %h instr %h req %b expected 0 0 0 %h 0",
                     if_valid, if_pc, if_pc_plus4, if_instr, imem_req, NOP);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        resp_delay = 0;
        imem_ready = 1'b1;
        step_until_addr(32'h4, found);
        imem_ready = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL restart_reach: fetch of 00000004 not seen"); end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL restart_drain: %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        resp_delay    = 0;
        reset         = 1'b1;
        pc_src        = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        imem_ready    = 1'b0;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_drop();
        test_flush_stall();
        test_wrap_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
